// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port dmem between the processor (port 0)
// and a secondary master (port 1), with optional locked bursts and 1-cycle read return.
module dmem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam bit BURST_EN = (MAX_BURST > 1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rvalid_q, rvalid_d;

  logic [1:0] gnt;
  logic       owner_hit;
  logic       owner_idx;
  logic       any_gnt;
  logic       win_idx;
  logic       win_lock;
  logic       win_we;

  // The locked owner keeps the port only while it still requests; otherwise
  // fall straight back to round-robin in the same cycle.
  always_comb begin
    owner_idx = (state_q == ST_OWN1);
    owner_hit = ((state_q == ST_OWN0) && req_i[0]) || ((state_q == ST_OWN1) && req_i[1]);
    gnt       = 2'b00;
    if (!rst) begin
      if (owner_hit) begin
        gnt = owner_idx ? 2'b10 : 2'b01;
      end else if (req_i == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req_i;
      end
    end
    any_gnt  = |gnt;
    win_idx  = gnt[1];
    win_lock = win_idx ? lock_i[1] : lock_i[0];
    win_we   = win_idx ? we_i[1] : we_i[0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rvalid_d = gnt & ~we_i;
    if (any_gnt) begin
      last_d = win_idx;
    end
    case (state_q)
      ST_IDLE: begin
        if (any_gnt && win_lock && BURST_EN) begin
          state_d = win_idx ? ST_OWN1 : ST_OWN0;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (owner_hit && win_lock && (cnt_q < LAST_CNT)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o       = gnt;
  assign mem_we_o    = any_gnt & win_we;
  assign mem_addr_o  = !any_gnt ? '0 : (win_idx ? addr1_i : addr0_i);
  assign mem_wdata_o = !any_gnt ? '0 : (win_idx ? wdata1_i : wdata0_i);
  assign rdata_o     = mem_rdata_i;

  // A return still in flight when reset hits is dropped, not delivered late.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      assign rvalid_o[gi] = rvalid_q[gi] & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model and a dmem model.
module tb_dmem_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] w0, w1;
  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, mem_wdata_o, mem_rdata_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;

  int total = 0;
  int bad = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr0_i(a0), .addr1_i(a1), .wdata0_i(w0), .wdata1_i(w1),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int i);
    return DW'((i * 935) ^ 23644);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port dmem, one-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
    ram[5] = 16'hBEEF;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      mem_rdata_i = ram[mem_addr_o];
      if (mem_we_o) ram[mem_addr_o] = mem_wdata_o;
    end
  end

  // Behavioural model: owner (-1 = none), grants used by owner, last winner,
  // shadow memory updated in grant order.
  logic [DW-1:0] shadow [DEPTH];
  int            m_owner, m_used, m_last, m_g;
  logic [1:0]    m_rv_pend, e_gnt, e_rv, n_rv;
  logic [DW-1:0] m_pend_data, n_data, e_wd;
  logic [AW-1:0] e_addr;
  logic          e_we;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    shadow[5] = 16'hBEEF;
    m_owner = -1; m_used = 0; m_last = 1; m_rv_pend = 2'b00; m_pend_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_g = -1;
        e_rv = 2'b00;
      end else begin
        e_rv = m_rv_pend;
        if (m_owner >= 0 && req[m_owner]) m_g = m_owner;
        else if (req == 2'b11) m_g = 1 - m_last;
        else if (req[0]) m_g = 0;
        else if (req[1]) m_g = 1;
        else m_g = -1;
      end
      e_gnt  = (m_g < 0) ? 2'b00 : ((m_g == 0) ? 2'b01 : 2'b10);
      e_we   = (m_g >= 0) && we[m_g];
      e_addr = (m_g == 0) ? a0 : ((m_g == 1) ? a1 : '0);
      e_wd   = (m_g == 0) ? w0 : ((m_g == 1) ? w1 : '0);
      chk("gnt", 32'(gnt_o), 32'(e_gnt));
      chk("mem_we", 32'(mem_we_o), 32'(e_we));
      chk("mem_addr", 32'(mem_addr_o), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata_o), 32'(e_wd));
      chk("rvalid", 32'(rvalid_o), 32'(e_rv));
      if (e_rv != 2'b00) chk("rdata", 32'(rdata_o), 32'(m_pend_data));
      if (rst) begin
        m_owner = -1; m_used = 0; m_last = 1; m_rv_pend = 2'b00;
      end else begin
        n_rv = 2'b00;
        n_data = m_pend_data;
        if (m_g >= 0) begin
          m_last = m_g;
          if (e_we) shadow[e_addr] = e_wd;
          else begin
            n_rv = e_gnt;
            n_data = shadow[e_addr];
          end
        end
        if (m_owner >= 0) begin
          if (req[m_owner]) begin
            m_used++;
            if (!lock[m_owner] || m_used >= MB) begin m_owner = -1; m_used = 0; end
          end else begin
            m_owner = -1; m_used = 0;
          end
        end else if (m_g >= 0 && lock[m_g] && MB > 1) begin
          m_owner = m_g; m_used = 1;
        end
        m_rv_pend = n_rv;
        m_pend_data = n_data;
      end
    end
  end

  // Apply one cycle of inputs just after the edge, return just after the next falling edge.
  task automatic cyc(input logic rs, input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(posedge clk); #1;
    rst = rs; req = r; lock = l; we = w; a0 = ad0; a1 = ad1; w0 = d0; w1 = d1;
    @(negedge clk); #1;
  endtask

  logic [1:0]    g_prev;
  logic [1:0]    nr, nl, nw;
  logic [AW-1:0] na [2];
  logic [DW-1:0] nd [2];
  logic          nrst;

  initial begin
    rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b00;
    a0 = 13'd1; a1 = 13'd2; w0 = '0; w1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'h0);

    // Alternation of two readers right after reset.
    cyc(0, 2'b11, 2'b00, 2'b00, 13'd1, 13'd2, '0, '0); chk("rr0", 32'(gnt_o), 32'h1); chk("rr0_rv", 32'(rvalid_o), 32'h0);
    cyc(0, 2'b11, 2'b00, 2'b00, 13'd1, 13'd2, '0, '0); chk("rr1", 32'(gnt_o), 32'h2); chk("rr1_rv", 32'(rvalid_o), 32'h1);
    cyc(0, 2'b11, 2'b00, 2'b00, 13'd1, 13'd2, '0, '0); chk("rr2", 32'(gnt_o), 32'h1); chk("rr2_rv", 32'(rvalid_o), 32'h2);
    cyc(0, 2'b11, 2'b00, 2'b00, 13'd1, 13'd2, '0, '0); chk("rr3", 32'(gnt_o), 32'h2);

    // Single read of 0x005.
    cyc(0, 2'b01, 2'b00, 2'b00, 13'h005, 13'd2, '0, '0);
    chk("beef_gnt", 32'(gnt_o), 32'h1); chk("beef_addr", 32'(mem_addr_o), 32'h5);
    cyc(0, 2'b00, 2'b00, 2'b00, 13'h005, 13'd2, '0, '0);
    chk("beef_rv", 32'(rvalid_o), 32'h1); chk("beef_data", 32'(rdata_o), 32'hBEEF);

    // Locked burst by port 1 while port 0 waits.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b11, 2'b10, 2'b00, 13'd3, 13'd4, '0, '0);
      chk($sformatf("burst%0d", i), 32'(gnt_o), 32'h2);
    end
    cyc(0, 2'b11, 2'b10, 2'b00, 13'd3, 13'd4, '0, '0); chk("burst_end", 32'(gnt_o), 32'h1);
    cyc(0, 2'b11, 2'b10, 2'b00, 13'd3, 13'd4, '0, '0); chk("burst_new", 32'(gnt_o), 32'h2);
    // Owner drops its request: port 0 wins in the same cycle.
    cyc(0, 2'b01, 2'b10, 2'b00, 13'd3, 13'd4, '0, '0); chk("drop", 32'(gnt_o), 32'h1);

    // Write by port 0 ordered ahead of a read by port 1 to the same word.
    cyc(0, 2'b10, 2'b00, 2'b00, 13'd3, 13'd7, '0, '0); chk("prep", 32'(gnt_o), 32'h2);
    cyc(0, 2'b11, 2'b00, 2'b01, 13'h010, 13'h010, 16'h1234, '0);
    chk("wr_gnt", 32'(gnt_o), 32'h1); chk("wr_we", 32'(mem_we_o), 32'h1);
    chk("wr_data", 32'(mem_wdata_o), 32'h1234);
    cyc(0, 2'b10, 2'b00, 2'b00, 13'h010, 13'h010, '0, '0);
    chk("rd_gnt", 32'(gnt_o), 32'h2); chk("wr_no_rv", 32'(rvalid_o), 32'h0);
    cyc(0, 2'b00, 2'b00, 2'b00, 13'h010, 13'h010, '0, '0);
    chk("rd_rv", 32'(rvalid_o), 32'h2); chk("rd_data", 32'(rdata_o), 32'h1234);

    // Reset right after a locked read grant.
    cyc(0, 2'b01, 2'b01, 2'b00, 13'd3, 13'd4, '0, '0); chk("pre_rst", 32'(gnt_o), 32'h1);
    cyc(1, 2'b01, 2'b01, 2'b00, 13'd3, 13'd4, '0, '0);
    chk("mid_rst_gnt", 32'(gnt_o), 32'h0); chk("mid_rst_rv", 32'(rvalid_o), 32'h0);
    cyc(0, 2'b11, 2'b00, 2'b00, 13'd3, 13'd4, '0, '0);
    chk("post_rst_gnt", 32'(gnt_o), 32'h1); chk("post_rst_rv", 32'(rvalid_o), 32'h0);
    cyc(0, 2'b11, 2'b00, 2'b00, 13'd3, 13'd4, '0, '0); chk("post_rst_rr", 32'(gnt_o), 32'h2);

    // Randomized traffic: requests held until granted, occasionally dropped.
    nr = req; nl = lock; nw = we; na[0] = a0; na[1] = a1; nd[0] = w0; nd[1] = w1;
    for (int c = 0; c < 3000; c++) begin
      g_prev = gnt_o;
      for (int p = 0; p < 2; p++) begin
        if (!nr[p] || g_prev[p] || $urandom_range(0, 7) == 0) begin
          nr[p] = ($urandom_range(0, 2) != 0);
          nl[p] = ($urandom_range(0, 1) != 0);
          nw[p] = ($urandom_range(0, 2) == 0);
          na[p] = AW'($urandom_range(0, 15));
          nd[p] = DW'($urandom);
        end
      end
      nrst = ($urandom_range(0, 99) == 0);
      cyc(nrst, nr, nl, nw, na[0], na[1], nd[0], nd[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
